// File: rtl/m_fetch_queue.sv
// Instruction fetch unit with a DEPTH-entry decoupling queue, one outstanding
// memory request, redirect flush and halt detection. Optional: FETCH_QUEUE_BYPASS_EN.
module m_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic        w_ce,
  output logic        o_imem_req,
  output logic [11:0] o_imem_addr,
  input  logic [31:0] i_imem_data,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  input  logic        i_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_halted
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] HALT_WORD = 32'h000f_0033;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [31:0]     inflight_pc_q, inflight_pc_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic            halted_q, halted_d;

  logic            empty, credit_ok, issue, push, pop, enq, deq, halt_hit, bypass_vld;
  logic [AW+1:0]   occupancy;
  entry_t          head;

  assign empty     = (count_q == '0);
  // Queued entries plus the outstanding response must fit, so a push never overflows.
  assign occupancy = (AW+2)'(count_q) + (AW+2)'(inflight_q);
  assign credit_ok = occupancy < (AW+2)'(DEPTH);

  assign issue    = w_rst_n & w_ce & ~halted_q & ~i_redirect & credit_ok;
  assign push     = w_rst_n & w_ce & inflight_q & ~i_redirect;
  assign halt_hit = push & (i_imem_data == HALT_WORD);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_vld = push & empty;
`else
  assign bypass_vld = 1'b0;
`endif

  assign head    = mem[rd_ptr_q];
  assign o_valid = w_rst_n & (~empty | bypass_vld);
  assign pop     = o_valid & i_ready & w_ce & ~i_redirect;
  // A bypassed response that decode takes this cycle never occupies a slot.
  assign enq     = push & ~(bypass_vld & pop);
  assign deq     = pop & ~empty;

  always_comb begin
    o_pc    = 32'h0;
    o_instr = NOP_WORD;
    if (o_valid) begin
      if (empty) begin
        o_pc    = inflight_pc_q;
        o_instr = i_imem_data;
      end else begin
        o_pc    = head.pc;
        o_instr = head.instr;
      end
    end
  end

  assign o_imem_req  = issue;
  assign o_imem_addr = fetch_pc_q[13:2];
  assign o_halted    = halted_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    halted_d      = halted_q;
    if (w_ce) begin
      if (i_redirect) begin
        fetch_pc_d = i_redirect_pc;
        inflight_d = 1'b0;
        count_d    = '0;
        rd_ptr_d   = '0;
        wr_ptr_d   = '0;
        halted_d   = 1'b0;
      end else begin
        if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
        if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + (AW+1)'(enq) - (AW+1)'(deq);
        if (issue) begin
          fetch_pc_d    = fetch_pc_q + 32'd4;
          inflight_pc_d = fetch_pc_q;
        end
        // The request issued alongside a halt word is discarded on return.
        inflight_d = issue & ~halt_hit;
        if (halt_hit) halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge w_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from the same sampled values.
    if (!w_rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      halted_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      halted_q      <= halted_d;
    end
  end

  // NOTE: queue storage is not reset; count_q alone decides which slots hold valid data.
  always_ff @(posedge w_clk) begin
    if (enq) mem[wr_ptr_q] <= '{pc: inflight_pc_q, instr: i_imem_data};
  end

endmodule
